// File: rtl/bomb_placer.sv
// bomb_placer: owns the registered 10x10 bomb map that feeds the countdown stage.
// Each bomb tick the map is reloaded from the countdown stage's output. New bombs
// requested by players A and B are then written on top of that reload. Each player
// has a limit on live bombs and, optionally, a cooldown after each placement.
// Optional feature macro: PLACE_COOLDOWN_EN. When it is defined, a player enters a
// cooldown state for COOLDOWN_CYC cycles after each accepted placement.
// Cell (x,y) is stored at bits [2i+1:2i], where i = 10*x + y.
module bomb_placer #(
  parameter int MAX_BOMBS    = 2,
  parameter int COOLDOWN_CYC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bombTick,
  input  logic [199:0] i_updatedBombMap,
  input  logic         placeA,
  input  logic         placeB,
  input  logic [3:0]   playerAx,
  input  logic [3:0]   playerAy,
  input  logic [3:0]   playerBx,
  input  logic [3:0]   playerBy,
  input  logic [1:0]   game_state,
  output logic [199:0] o_curBombMap,
  output logic [2:0]   o_bombCntA,
  output logic [2:0]   o_bombCntB,
  output logic         o_placedA,
  output logic         o_placedB
);

  localparam int NCELL = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } state_t;

  // Index 0 is player A and index 1 is player B throughout this module.
  logic [199:0]     interior_mask;
  logic [199:0]     base_map;
  logic [199:0]     map_next;
  logic [199:0]     map_reg;
  logic [NCELL-1:0] occupied;
  logic [NCELL-1:0] owner_reg   [2];
  logic [NCELL-1:0] owner_next  [2];
  logic [NCELL-1:0] place_bits  [2];
  logic [2:0]       cnt_reg     [2];
  logic [3:0]       pos_x       [2];
  logic [3:0]       pos_y       [2];
  state_t           state_reg   [2];
  state_t           state_next  [2];
  logic [1:0]       place_lvl;
  logic [1:0]       prev_reg;
  logic [1:0]       req_edge;
  logic [1:0]       accept;
  logic [1:0]       placed_reg;

`ifdef PLACE_COOLDOWN_EN
  localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_CYC - 1);
  logic [7:0] cool_reg  [2];
  logic [7:0] cool_next [2];
`endif

  assign place_lvl = {placeB, placeA};
  assign pos_x[0]  = playerAx;
  assign pos_y[0]  = playerAy;
  assign pos_x[1]  = playerBx;
  assign pos_y[1]  = playerBy;

  // A request is the rising edge of the button level. A held button places only once.
  assign req_edge = place_lvl & ~prev_reg;

  // Per-cell constants and occupancy. Border rows and columns (0 and 9) are masked off.
  genvar gi;
  generate
    for (gi = 0; gi < NCELL; gi++) begin : g_cell
      localparam int CX = gi / 10;
      localparam int CY = gi % 10;
      localparam bit INSIDE = (CX >= 1) && (CX <= 8) && (CY >= 1) && (CY <= 8);
      assign interior_mask[2*gi +: 2] = INSIDE ? 2'b11 : 2'b00;
      assign occupied[gi]             = |map_next[2*gi +: 2];
    end

    // Ownership is kept only while the cell is still occupied in the next map.
    // When a bomb explodes, the countdown stage returns 0 for that cell and the owner bit clears.
    for (gi = 0; gi < 2; gi++) begin : g_owner
      assign owner_next[gi] = (owner_reg[gi] & occupied) | place_bits[gi];
    end
  endgenerate

  // Base map for this cycle: the tick reload when bombTick is high, otherwise the held map.
  assign base_map = (bombTick ? i_updatedBombMap : map_reg) & interior_mask;

  // Place new bombs on top of the base map. A is evaluated first.
  // If A and B request the same cell, B therefore sees the cell as occupied and is rejected.
  always_comb begin
    logic coord_ok;
    int   idx;
    map_next      = base_map;
    accept        = 2'b00;
    place_bits[0] = '0;
    place_bits[1] = '0;
    for (int p = 0; p < 2; p++) begin
      coord_ok = (pos_x[p] >= 4'd1) && (pos_x[p] <= 4'd8) &&
                 (pos_y[p] >= 4'd1) && (pos_y[p] <= 4'd8);
      idx      = coord_ok ? (10 * int'(pos_x[p]) + int'(pos_y[p])) : 0;
      if ((state_reg[p] == REQ) && (game_state == 2'd0) && coord_ok &&
          (map_next[2*idx +: 2] == 2'd0) && (int'(cnt_reg[p]) < MAX_BOMBS)) begin
        accept[p]            = 1'b1;
        map_next[2*idx +: 2] = 2'd1;
        place_bits[p][idx]   = 1'b1;
      end
    end
  end

  // Per-player request FSM: IDLE -> REQ -> (COOL ->) IDLE.
  // Edges that arrive outside IDLE are dropped, not queued.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_next[p] = state_reg[p];
`ifdef PLACE_COOLDOWN_EN
      cool_next[p]  = cool_reg[p];
`endif
      case (state_reg[p])
        IDLE: begin
          if (req_edge[p]) state_next[p] = REQ;
        end
        REQ: begin
`ifdef PLACE_COOLDOWN_EN
          if (accept[p]) begin
            state_next[p] = COOL;
            cool_next[p]  = COOL_INIT;
          end else begin
            state_next[p] = IDLE;
          end
`else
          state_next[p] = IDLE;
`endif
        end
        COOL: begin
`ifdef PLACE_COOLDOWN_EN
          if (cool_reg[p] == 8'd0) state_next[p] = IDLE;
          else                     cool_next[p]  = cool_reg[p] - 8'd1;
`else
          state_next[p] = IDLE;
`endif
        end
        default: state_next[p] = IDLE;
      endcase
    end
  end

  // State registers. The map, ownership, counts and placed pulses all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      map_reg    <= '0;
      prev_reg   <= '0;
      placed_reg <= '0;
      for (int p = 0; p < 2; p++) begin
        owner_reg[p] <= '0;
        cnt_reg[p]   <= '0;
        state_reg[p] <= IDLE;
`ifdef PLACE_COOLDOWN_EN
        cool_reg[p]  <= '0;
`endif
      end
    end else begin
      map_reg    <= map_next;
      prev_reg   <= place_lvl;
      placed_reg <= accept;
      for (int p = 0; p < 2; p++) begin
        owner_reg[p] <= owner_next[p];
        cnt_reg[p]   <= 3'($countones(owner_next[p]));
        state_reg[p] <= state_next[p];
`ifdef PLACE_COOLDOWN_EN
        cool_reg[p]  <= cool_next[p];
`endif
      end
    end
  end

  assign o_curBombMap = map_reg;
  assign o_bombCntA   = cnt_reg[0];
  assign o_bombCntB   = cnt_reg[1];
  assign o_placedA    = placed_reg[0];
  assign o_placedB    = placed_reg[1];

endmodule
